// File: rtl/mips_reg_arbiter.sv
// mips_reg_arbiter
//   Shares one MIPS register file (two combinational read ports A/B and one
//   edge-triggered write port) between two requesters. Requester 0 always reads
//   through port A and requester 1 through port B, so reads never conflict.
//   The single write port is arbitrated round-robin. A built-in clear sequencer
//   zeroes registers 1..NREG-1 when Clr_Start is pulsed.
//
// Ports
//   Clk, Reset               clock (rising edge), async active-low reset
//   Clr_Start / Clr_Busy     start pulse / busy flag of the clear sweep
//   Req0/1, Wr0/1            request (held until Ack), 1 = write, 0 = read
//   Addr0/1, WData0/1        transaction address and write data
//   Ack0/1, RData0/1         registered completion pulse and read data
//   R_Addr_A/B, R_Data_A/B   register file read ports
//   W_Addr, W_Data, Write_Reg register file write port
module mips_reg_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clr_Start,
  output logic              Clr_Busy,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              Wr0,
  input  logic              Wr1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Ack0,
  output logic              Ack1,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  output logic [ADDR_W-1:0] R_Addr_A,
  output logic [ADDR_W-1:0] R_Addr_B,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic              Write_Reg,
  input  logic [DATA_W-1:0] R_Data_A,
  input  logic [DATA_W-1:0] R_Data_B
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LP_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] LP_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NREG - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [ADDR_W-1:0]   w_clr_cnt_nxt;
  logic                r_clr_busy;
  logic                r_last_w;
  logic                r_ack0;
  logic                r_ack1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  logic                w_elig0;
  logic                w_elig1;
  logic                w_rd_g0;
  logic                w_rd_g1;
  logic                w_wr_c0;
  logic                w_wr_c1;
  logic                w_wr_g0;
  logic                w_wr_g1;
  logic [ADDR_W-1:0]   w_w_addr;
  logic [DATA_W-1:0]   w_w_data;
  logic                w_w_en;

  // A requester is never eligible in its own Ack cycle, nor while the sweep
  // runs; gating with Reset keeps every output at 0 while reset is asserted.
  assign w_elig0 = Reset & Req0 & ~r_ack0 & (r_state == ST_IDLE);
  assign w_elig1 = Reset & Req1 & ~r_ack1 & (r_state == ST_IDLE);
  assign w_rd_g0 = w_elig0 & ~Wr0;
  assign w_rd_g1 = w_elig1 & ~Wr1;
  assign w_wr_c0 = w_elig0 & Wr0;
  assign w_wr_c1 = w_elig1 & Wr1;
  // On a conflict the requester that did not win last time is granted.
  assign w_wr_g0 = w_wr_c0 & (~w_wr_c1 | r_last_w);
  assign w_wr_g1 = w_wr_c1 & (~w_wr_c0 | ~r_last_w);

  assign R_Addr_A  = Reset ? Addr0 : LP_ZERO;
  assign R_Addr_B  = Reset ? Addr1 : LP_ZERO;
  assign W_Addr    = w_w_addr;
  assign W_Data    = w_w_data;
  assign Write_Reg = w_w_en;
  assign Clr_Busy  = r_clr_busy;
  assign Ack0      = r_ack0;
  assign Ack1      = r_ack1;
  assign RData0    = r_rdata0;
  assign RData1    = r_rdata1;

  // Next-state logic and write-port steering.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_w_addr      = LP_ZERO;
    w_w_data      = {DATA_W{1'b0}};
    w_w_en        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Clr_Start) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_cnt_nxt = LP_ONE;
        end else begin
          w_state_nxt   = ST_IDLE;
          w_clr_cnt_nxt = r_clr_cnt;
        end
        // A write to $0 is acknowledged but never reaches the register file.
        if (w_wr_g0 && (Addr0 != LP_ZERO)) begin
          w_w_addr = Addr0;
          w_w_data = WData0;
          w_w_en   = 1'b1;
        end else if (w_wr_g1 && (Addr1 != LP_ZERO)) begin
          w_w_addr = Addr1;
          w_w_data = WData1;
          w_w_en   = 1'b1;
        end else begin
          w_w_en   = 1'b0;
        end
      end
      ST_CLEAR: begin
        w_w_addr = r_clr_cnt;
        w_w_data = {DATA_W{1'b0}};
        w_w_en   = 1'b1;
        if (r_clr_cnt == LP_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_clr_cnt_nxt = LP_ZERO;
        end else begin
          w_state_nxt   = ST_CLEAR;
          w_clr_cnt_nxt = r_clr_cnt + LP_ONE;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_clr_cnt_nxt = LP_ZERO;
      end
    endcase
  end

  // Sequencer state, clear counter and busy flag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= ST_IDLE;
      r_clr_cnt  <= LP_ZERO;
      r_clr_busy <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_cnt  <= w_clr_cnt_nxt;
      r_clr_busy <= (w_state_nxt == ST_CLEAR);
    end
  end

  // Round-robin pointer: only a real conflict moves it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_last_w <= 1'b1;
    end else if (w_wr_c0 && w_wr_c1) begin
      r_last_w <= w_wr_g1;
    end else begin
      r_last_w <= r_last_w;
    end
  end

  // Completion pulses and captured read data (old value on same-edge write).
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= {DATA_W{1'b0}};
      r_rdata1 <= {DATA_W{1'b0}};
    end else begin
      r_ack0 <= w_rd_g0 | w_wr_g0;
      r_ack1 <= w_rd_g1 | w_wr_g1;
      if (w_rd_g0) begin
        r_rdata0 <= R_Data_A;
      end else begin
        r_rdata0 <= r_rdata0;
      end
      if (w_rd_g1) begin
        r_rdata1 <= R_Data_B;
      end else begin
        r_rdata1 <= r_rdata1;
      end
    end
  end

endmodule

// File: tb/tb_mips_reg_arbiter.sv
// tb_mips_reg_arbiter
//   Directed bench for mips_reg_arbiter with a small MIPS register file model
//   attached to its read/write ports. Registers are preset to 32'hA500_00nn.
module tb_mips_reg_arbiter;

  logic        Clk;
  logic        Reset;
  logic        Clr_Start;
  logic        Clr_Busy;
  logic        Req0, Req1, Wr0, Wr1;
  logic [4:0]  Addr0, Addr1;
  logic [31:0] WData0, WData1;
  logic        Ack0, Ack1;
  logic [31:0] RData0, RData1;
  logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
  logic [31:0] W_Data;
  logic        Write_Reg;
  logic [31:0] R_Data_A, R_Data_B;

  logic [31:0] rf [0:31];
  logic        rf_preset;
  int          n_checks;
  int          n_errors;
  int          busy_cycles;

  mips_reg_arbiter #(.ADDR_W(5), .DATA_W(32), .NREG(32)) dut (
    .Clk(Clk), .Reset(Reset), .Clr_Start(Clr_Start), .Clr_Busy(Clr_Busy),
    .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Ack0(Ack0), .Ack1(Ack1), .RData0(RData0), .RData1(RData1),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr), .W_Data(W_Data),
    .Write_Reg(Write_Reg), .R_Data_A(R_Data_A), .R_Data_B(R_Data_B)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file model: combinational reads, $0 hard-wired to zero.
  always @(posedge Clk) begin
    if (rf_preset) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h0 : (32'hA500_0000 | 32'(i));
    end else if (Write_Reg && (W_Addr != 5'd0)) begin
      rf[W_Addr] <= W_Data;
    end
  end
  assign R_Data_A = rf[R_Addr_A];
  assign R_Data_B = rf[R_Addr_B];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; busy_cycles = 0;
    Reset = 1'b0; rf_preset = 1'b1; Clr_Start = 1'b0;
    Req0 = 1'b0; Req1 = 1'b0; Wr0 = 1'b0; Wr1 = 1'b0;
    Addr0 = 5'd3; Addr1 = 5'd0; WData0 = 32'h0; WData1 = 32'h0;
    #1;
    chk("rst_raddr_a", {27'd0, R_Addr_A}, 32'h0);
    chk("rst_busy", {31'd0, Clr_Busy}, 32'h0);
    chk("rst_wen", {31'd0, Write_Reg}, 32'h0);
    tick();
    rf_preset = 1'b0;
    tick();
    Reset = 1'b1; Addr0 = 5'd0;
    #1;
    chk("rst_ack0", {31'd0, Ack0}, 32'h0);
    chk("rst_ack1", {31'd0, Ack1}, 32'h0);
    chk("rst_rdata0", RData0, 32'h0);
    chk("rst_rdata1", RData1, 32'h0);

    // 1: reset mid-sweep while the 10th register is being addressed
    Clr_Start = 1'b1;
    tick();
    Clr_Start = 1'b0;
    chk("t1_busy", {31'd0, Clr_Busy}, 32'h1);
    chk("t1_waddr1", {27'd0, W_Addr}, 32'h1);
    chk("t1_wen", {31'd0, Write_Reg}, 32'h1);
    repeat (9) tick();
    chk("t1_waddr10", {27'd0, W_Addr}, 32'hA);
    #2 Reset = 1'b0;
    #1;
    chk("t1_async_wen", {31'd0, Write_Reg}, 32'h0);
    chk("t1_async_waddr", {27'd0, W_Addr}, 32'h0);
    chk("t1_async_busy", {31'd0, Clr_Busy}, 32'h0);
    tick();
    Reset = 1'b1;
    tick();
    chk("t1_idle", {31'd0, Clr_Busy}, 32'h0);
    chk("t1_rf1", rf[1], 32'h0);
    chk("t1_rf9", rf[9], 32'h0);
    chk("t1_rf10", rf[10], 32'hA500_000A);
    chk("t1_rf31", rf[31], 32'hA500_001F);

    // 2: write then read back by requester 0
    Req0 = 1'b1; Wr0 = 1'b1; Addr0 = 5'd5; WData0 = 32'h1234_5678;
    #1;
    chk("t2_wen", {31'd0, Write_Reg}, 32'h1);
    chk("t2_waddr", {27'd0, W_Addr}, 32'h5);
    chk("t2_wdata", W_Data, 32'h1234_5678);
    tick();
    chk("t2_ack_w", {31'd0, Ack0}, 32'h1);
    Req0 = 1'b0;
    chk("t2_wen_once", {31'd0, Write_Reg}, 32'h0);
    tick();
    chk("t2_ack_drop", {31'd0, Ack0}, 32'h0);
    Req0 = 1'b1; Wr0 = 1'b0;
    tick();
    chk("t2_ack_r", {31'd0, Ack0}, 32'h1);
    chk("t2_rdata", RData0, 32'h1234_5678);
    Req0 = 1'b0;
    tick();
    chk("t2_ack_end", {31'd0, Ack0}, 32'h0);

    // 3: write conflicts, first one after reset goes to requester 0
    Req0 = 1'b1; Wr0 = 1'b1; Addr0 = 5'd3; WData0 = 32'h89AB_CDEF;
    Req1 = 1'b1; Wr1 = 1'b1; Addr1 = 5'd4; WData1 = 32'h7766_AABB;
    #1;
    chk("t3_first_waddr", {27'd0, W_Addr}, 32'h3);
    tick();
    chk("t3_ack0", {31'd0, Ack0}, 32'h1);
    chk("t3_ack1_wait", {31'd0, Ack1}, 32'h0);
    Req0 = 1'b0;
    chk("t3_second_waddr", {27'd0, W_Addr}, 32'h4);
    tick();
    chk("t3_ack1", {31'd0, Ack1}, 32'h1);
    chk("t3_ack0_drop", {31'd0, Ack0}, 32'h0);
    Req1 = 1'b0;
    tick();
    chk("t3_rf3", rf[3], 32'h89AB_CDEF);
    chk("t3_rf4", rf[4], 32'h7766_AABB);
    Req0 = 1'b1; WData0 = 32'h0000_0033;
    Req1 = 1'b1; WData1 = 32'h0000_0044;
    #1;
    chk("t3_rep_waddr", {27'd0, W_Addr}, 32'h4);
    tick();
    chk("t3_rep_ack1", {31'd0, Ack1}, 32'h1);
    chk("t3_rep_ack0_wait", {31'd0, Ack0}, 32'h0);
    Req1 = 1'b0;
    tick();
    chk("t3_rep_ack0", {31'd0, Ack0}, 32'h1);
    Req0 = 1'b0;
    tick();
    chk("t3_rep_rf3", rf[3], 32'h0000_0033);
    chk("t3_rep_rf4", rf[4], 32'h0000_0044);

    // 4: same-cycle read of the register being written returns old data
    Req0 = 1'b1; Wr0 = 1'b1; Addr0 = 5'd7; WData0 = 32'h1122_3344;
    tick();
    Req0 = 1'b0;
    tick();
    Req0 = 1'b1; Wr0 = 1'b1; Addr0 = 5'd7; WData0 = 32'h2014_0316;
    Req1 = 1'b1; Wr1 = 1'b0; Addr1 = 5'd7;
    tick();
    chk("t4_ack0", {31'd0, Ack0}, 32'h1);
    chk("t4_ack1", {31'd0, Ack1}, 32'h1);
    chk("t4_old", RData1, 32'h1122_3344);
    Req0 = 1'b0; Req1 = 1'b0;
    tick();
    Req1 = 1'b1;
    tick();
    chk("t4_new", RData1, 32'h2014_0316);
    Req1 = 1'b0;
    tick();

    // 5: write to $0 is acknowledged but suppressed
    Req0 = 1'b1; Wr0 = 1'b1; Addr0 = 5'd0; WData0 = 32'hFFFF_FFFF;
    #1;
    chk("t5_wen", {31'd0, Write_Reg}, 32'h0);
    chk("t5_wdata", W_Data, 32'h0);
    tick();
    chk("t5_ack", {31'd0, Ack0}, 32'h1);
    Req0 = 1'b0;
    tick();
    Req0 = 1'b1; Wr0 = 1'b0;
    tick();
    chk("t5_read0", RData0, 32'h0);
    Req0 = 1'b0;
    tick();

    // 6: clear sweep with a pending read and an ignored second start
    Clr_Start = 1'b1;
    tick();
    Clr_Start = 1'b0;
    Req1 = 1'b1; Wr1 = 1'b0; Addr1 = 5'd5;
    while (Clr_Busy && busy_cycles < 40) begin
      busy_cycles++;
      chk("t6_waddr", {27'd0, W_Addr}, 32'(busy_cycles));
      chk("t6_ack1_held", {31'd0, Ack1}, 32'h0);
      if (busy_cycles == 5) Clr_Start = 1'b1;
      tick();
      Clr_Start = 1'b0;
    end
    chk("t6_busy_len", 32'(busy_cycles), 32'd31);
    chk("t6_ack1_first_idle", {31'd0, Ack1}, 32'h0);
    tick();
    chk("t6_ack1", {31'd0, Ack1}, 32'h1);
    chk("t6_rdata1", RData1, 32'h0);
    Req1 = 1'b0;
    tick();
    chk("t6_busy_end", {31'd0, Clr_Busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
